// File: rtl/vecmac_pkg.sv
// Shared types and constants for the vecmac sequencer slice.
//   state_t      : sequencer states
//   LANES/LANE_W : int8 lanes per 32-bit operand word
//   PROD_W       : width of one lane product
//   LSUM_W       : width of the four-lane product sum (max 4*255*255 = 260100)
package vecmac_pkg;

    localparam int unsigned LANES     = 4;
    localparam int unsigned LANE_W    = 8;
    localparam int unsigned PROD_W    = 16;
    localparam int unsigned LSUM_W    = 18;

    localparam int unsigned LEN_W_DEF = 16;
    localparam int unsigned ACC_W_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_DONE
    } state_t;

endpackage

// File: rtl/vecmac_lane_sum.sv
// Combinational sum of the four unsigned 16-bit lane products returned by the
// multiplier.
//   product  : {p3,p2,p1,p0}, PROD_W bits each
//   lane_sum : zero-extended sum of all lanes, LSUM_W bits
module vecmac_lane_sum
    import vecmac_pkg::*;
(
    input  logic [LANES*PROD_W-1:0] product,
    output logic [LSUM_W-1:0]       lane_sum
);

    always_comb begin
        lane_sum = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            lane_sum = lane_sum + LSUM_W'(product[i*PROD_W +: PROD_W]);
        end
    end

endmodule

// File: rtl/vecmac_seq.sv
// Dot-product sequencer: accepts a command (length in 32-bit word pairs),
// streams operand pairs into an external 4-lane pipelined multiplier, sums
// every returned product word into an accumulator and presents the result.
//   clk, rst                       : clock, async active-high reset
//   cmd_valid/ready/len/acc_clr    : command port (ready only in IDLE)
//   op_valid/ready/a/b             : operand pair stream (ready only in ISSUE)
//   mul_in_valid/a/b               : issue port to the multiplier
//   mul_out_valid/mul_product      : multiplier result, no backpressure
//   res_valid/ready/data           : result port (res_data always == acc)
//   busy                           : sequencer not idle
module vecmac_seq
    import vecmac_pkg::*;
#(
    parameter int unsigned LEN_W = LEN_W_DEF,
    parameter int unsigned ACC_W = ACC_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [LEN_W-1:0]        cmd_len,
    input  logic                    cmd_acc_clr,
    input  logic                    op_valid,
    output logic                    op_ready,
    input  logic [31:0]             op_a,
    input  logic [31:0]             op_b,
    output logic                    mul_in_valid,
    output logic [31:0]             mul_in_a,
    output logic [31:0]             mul_in_b,
    input  logic                    mul_out_valid,
    input  logic [LANES*PROD_W-1:0] mul_product,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [ACC_W-1:0]        res_data,
    output logic                    busy
);

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   issue_cnt_q;
    logic [LEN_W-1:0]   ret_cnt_q;
    logic [LEN_W-1:0]   last_idx;
    logic [ACC_W-1:0]   acc_q;
    logic               mul_in_valid_q;
    logic [31:0]        mul_in_a_q;
    logic [31:0]        mul_in_b_q;
    logic [LSUM_W-1:0]  lane_sum;

    logic               cmd_hs;
    logic               issue_hs;
    logic               ret_take;

    vecmac_lane_sum u_lane_sum (
        .product  (mul_product),
        .lane_sum (lane_sum)
    );

    // Only meaningful for len_q >= 1; a zero-length command never leaves IDLE
    // for ISSUE, so the wrapped value is never compared.
    assign last_idx = len_q - LEN_W'(1);

    assign cmd_ready = (state_q == ST_IDLE);
    assign op_ready  = (state_q == ST_ISSUE);
    assign res_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);

    assign cmd_hs    = cmd_valid && cmd_ready;
    assign issue_hs  = op_valid && op_ready;
    // Results arriving in IDLE/DONE are stale (e.g. in flight across a reset).
    assign ret_take  = mul_out_valid &&
                       ((state_q == ST_ISSUE) || (state_q == ST_DRAIN));

    assign mul_in_valid = mul_in_valid_q;
    assign mul_in_a     = mul_in_a_q;
    assign mul_in_b     = mul_in_b_q;
    assign res_data     = acc_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_hs) begin
                    state_d = (cmd_len == '0) ? ST_DONE : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (issue_hs && (issue_cnt_q == last_idx)) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (mul_out_valid && (ret_cnt_q == last_idx)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_q          <= '0;
            issue_cnt_q    <= '0;
            ret_cnt_q      <= '0;
            acc_q          <= '0;
            mul_in_valid_q <= 1'b0;
            mul_in_a_q     <= '0;
            mul_in_b_q     <= '0;
        end else begin
            mul_in_valid_q <= issue_hs;

            if (cmd_hs) begin
                len_q       <= cmd_len;
                issue_cnt_q <= '0;
                ret_cnt_q   <= '0;
                if (cmd_acc_clr) begin
                    acc_q <= '0;
                end
            end

            if (issue_hs) begin
                mul_in_a_q  <= op_a;
                mul_in_b_q  <= op_b;
                issue_cnt_q <= issue_cnt_q + LEN_W'(1);
            end

            if (ret_take) begin
                acc_q     <= acc_q + ACC_W'(lane_sum);
                ret_cnt_q <= ret_cnt_q + LEN_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_vecmac_seq.sv
module tb_vecmac_seq;

    localparam int unsigned LEN_W   = 16;
    localparam int unsigned ACC_W   = 32;
    localparam int unsigned MUL_LAT = 3;

    logic               clk;
    logic               rst;
    logic               cmd_valid;
    logic               cmd_ready;
    logic [LEN_W-1:0]   cmd_len;
    logic               cmd_acc_clr;
    logic               op_valid;
    logic               op_ready;
    logic [31:0]        op_a;
    logic [31:0]        op_b;
    logic               mul_in_valid;
    logic [31:0]        mul_in_a;
    logic [31:0]        mul_in_b;
    logic               mul_out_valid;
    logic [63:0]        mul_product;
    logic               res_valid;
    logic               res_ready;
    logic [ACC_W-1:0]   res_data;
    logic               busy;

    // Behavioural multiplier, reset by the inverted sequencer reset.
    logic               mul_rst_n;
    logic               pv [MUL_LAT];
    logic [63:0]        pp [MUL_LAT];
    logic               inj_valid;
    logic [63:0]        inj_prod;

    int                 compared   = 0;
    int                 mismatched = 0;
    int                 issue_seen = 0;
    logic [ACC_W-1:0]   ref_acc;

    vecmac_seq #(
        .LEN_W (LEN_W),
        .ACC_W (ACC_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_len       (cmd_len),
        .cmd_acc_clr   (cmd_acc_clr),
        .op_valid      (op_valid),
        .op_ready      (op_ready),
        .op_a          (op_a),
        .op_b          (op_b),
        .mul_in_valid  (mul_in_valid),
        .mul_in_a      (mul_in_a),
        .mul_in_b      (mul_in_b),
        .mul_out_valid (mul_out_valid),
        .mul_product   (mul_product),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_data      (res_data),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] lane_mul(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        p = '0;
        for (int l = 0; l < 4; l++) begin
            p[l*16 +: 16] = 16'(a[l*8 +: 8]) * 16'(b[l*8 +: 8]);
        end
        return p;
    endfunction

    // Reference: plain int8 dot product of one word pair.
    function automatic logic [ACC_W-1:0] dot(input logic [31:0] a, input logic [31:0] b);
        int unsigned s;
        s = 0;
        for (int l = 0; l < 4; l++) begin
            s = s + int'(a[l*8 +: 8]) * int'(b[l*8 +: 8]);
        end
        return ACC_W'(s);
    endfunction

    assign mul_rst_n     = ~rst;
    assign mul_out_valid = pv[MUL_LAT-1] | inj_valid;
    assign mul_product   = inj_valid ? inj_prod : pp[MUL_LAT-1];

    always @(posedge clk or negedge mul_rst_n) begin
        if (!mul_rst_n) begin
            for (int i = 0; i < MUL_LAT; i++) begin
                pv[i] <= 1'b0;
                pp[i] <= '0;
            end
        end else begin
            pv[0] <= mul_in_valid;
            pp[0] <= lane_mul(mul_in_a, mul_in_b);
            for (int i = 1; i < MUL_LAT; i++) begin
                pv[i] <= pv[i-1];
                pp[i] <= pp[i-1];
            end
        end
    end

    always @(posedge clk) begin
        if (mul_in_valid) issue_seen <= issue_seen + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // gap >= 0: exactly that many idle cycles before each word; gap < 0: random 0..3.
    // exp_const >= 0 additionally checks the result against a fixed value.
    task automatic do_cmd(input int len, input bit clr, input int gap, input int hold,
                          input bit fixed, input logic [31:0] fa, input logic [31:0] fb,
                          input longint exp_const);
        int          start_iss;
        int          gaps;
        int          guard;
        bit          prev_mov;
        logic [31:0] a;
        logic [31:0] b;

        cmd_valid   = 1'b1;
        cmd_len     = LEN_W'(len);
        cmd_acc_clr = clr;
        check("cmd_ready_idle", 64'(cmd_ready), 64'd1);
        start_iss = issue_seen;
        step;
        cmd_valid = 1'b0;
        if (clr) ref_acc = '0;

        for (int i = 0; i < len; i++) begin
            gaps = (gap >= 0) ? gap : int'($urandom_range(3, 0));
            for (int g = 0; g < gaps; g++) begin
                op_valid = 1'b0;
                step;
                check("op_ready_gap", 64'(op_ready), 64'd1);
            end
            a = fixed ? fa : $urandom;
            b = fixed ? fb : $urandom;
            op_valid = 1'b1;
            op_a     = a;
            op_b     = b;
            step;
            op_valid = 1'b0;
            check("mul_in_valid_pulse", 64'(mul_in_valid), 64'd1);
            check("mul_in_a", 64'(mul_in_a), 64'(a));
            check("mul_in_b", 64'(mul_in_b), 64'(b));
            ref_acc = ref_acc + dot(a, b);
        end

        guard    = 0;
        prev_mov = 1'b0;
        while (!res_valid && guard < 100) begin
            prev_mov = mul_out_valid;
            step;
            guard++;
        end
        check("res_valid_seen", 64'(res_valid), 64'd1);
        if (len == 0) check("len0_latency", 64'(guard), 64'd0);
        else          check("rise_after_last_product", 64'(prev_mov), 64'd1);
        check("res_data", 64'(res_data), 64'(ref_acc));
        if (exp_const >= 0) check("res_data_const", 64'(res_data), 64'(exp_const));
        check("issue_count", 64'(issue_seen - start_iss), 64'(len));

        for (int h = 0; h < hold; h++) begin
            step;
            check("hold_res_valid", 64'(res_valid), 64'd1);
            check("hold_res_data", 64'(res_data), 64'(ref_acc));
            check("hold_cmd_ready", 64'(cmd_ready), 64'd0);
        end

        res_ready = 1'b1;
        step;
        res_ready = 1'b0;
        check("back_idle_cmd_ready", 64'(cmd_ready), 64'd1);
        check("back_idle_busy", 64'(busy), 64'd0);
        check("back_idle_res_valid", 64'(res_valid), 64'd0);
    endtask

    initial begin
        rst         = 1'b1;
        cmd_valid   = 1'b0;
        cmd_len     = '0;
        cmd_acc_clr = 1'b0;
        op_valid    = 1'b0;
        op_a        = '0;
        op_b        = '0;
        res_ready   = 1'b0;
        inj_valid   = 1'b0;
        inj_prod    = '0;
        ref_acc     = '0;

        step;
        step;
        check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_res_valid", 64'(res_valid), 64'd0);
        check("rst_op_ready", 64'(op_ready), 64'd0);
        check("rst_mul_in_valid", 64'(mul_in_valid), 64'd0);
        check("rst_mul_in_a", 64'(mul_in_a), 64'd0);
        check("rst_res_data", 64'(res_data), 64'd0);
        rst = 1'b0;
        step;

        do_cmd(1, 1'b1, 0, 0, 1'b1, 32'h04030201, 32'h01010101, 10);
        do_cmd(2, 1'b1, 0, 0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 520200);
        do_cmd(0, 1'b1, 0, 0, 1'b1, 32'h0, 32'h0, 0);
        do_cmd(1, 1'b1, 0, 0, 1'b1, 32'h000000FF, 32'h000000FF, 65025);
        do_cmd(1, 1'b0, 0, 0, 1'b1, 32'h000000FF, 32'h000000FF, 130050);
        do_cmd(0, 1'b0, 0, 0, 1'b1, 32'h0, 32'h0, 130050);
        do_cmd(3, 1'b1, 2, 5, 1'b0, 32'h0, 32'h0, -1);

        for (int n = 0; n < 8; n++) begin
            do_cmd(int'($urandom_range(6, 0)), 1'($urandom_range(1, 0)), -1,
                   int'($urandom_range(2, 0)), 1'b0, 32'h0, 32'h0, -1);
        end

        // Reset in the middle of DRAIN with products still in flight.
        cmd_valid   = 1'b1;
        cmd_len     = LEN_W'(4);
        cmd_acc_clr = 1'b1;
        step;
        cmd_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            op_valid = 1'b1;
            op_a     = $urandom;
            op_b     = $urandom;
            step;
        end
        op_valid = 1'b0;
        check("drain_busy", 64'(busy), 64'd1);
        check("drain_op_ready", 64'(op_ready), 64'd0);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_cmd_ready", 64'(cmd_ready), 64'd1);
        check("async_rst_busy", 64'(busy), 64'd0);
        check("async_rst_res_valid", 64'(res_valid), 64'd0);
        check("async_rst_op_ready", 64'(op_ready), 64'd0);
        check("async_rst_mul_in_valid", 64'(mul_in_valid), 64'd0);
        check("async_rst_mul_in_a", 64'(mul_in_a), 64'd0);
        check("async_rst_mul_in_b", 64'(mul_in_b), 64'd0);
        check("async_rst_res_data", 64'(res_data), 64'd0);
        step;
        rst = 1'b0;
        ref_acc = '0;
        step;

        inj_valid = 1'b1;
        inj_prod  = 64'h00FF00FF00FF00FF;
        step;
        inj_valid = 1'b0;
        step;
        check("late_product_ignored_acc", 64'(res_data), 64'd0);
        check("late_product_ignored_busy", 64'(busy), 64'd0);

        do_cmd(1, 1'b0, 0, 0, 1'b1, 32'h00000002, 32'h00000002, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
